// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the shared multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/writeback and tracks cycle and retire counts.
module multicycle_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 bcond,
    input  logic                 halt_cond,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [2:0]           state,
    output logic                 is_halted,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] retire_count
);

    localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD           = 7'b0000011;
    localparam logic [6:0] OP_STORE          = 7'b0100011;
    localparam logic [6:0] OP_BRANCH         = 7'b1100011;
    localparam logic [6:0] OP_JAL            = 7'b1101111;
    localparam logic [6:0] OP_JALR           = 7'b1100111;
    localparam logic [6:0] OP_ECALL          = 7'b1110011;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_JMP  = 3'd5,
        ST_BRT  = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    state_e                 state_q, state_d;
    logic                   illegal_op_q, illegal_op_d;
    logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0]   retire_count_q, retire_count_d;

    logic                   opcode_known;
    logic                   retire;

    logic                   pc_write_c;
    logic                   pc_source_c;
    logic                   i_or_d_c;
    logic                   mem_read_c;
    logic                   mem_write_c;
    logic                   ir_write_c;
    logic                   mem_to_reg_c;
    logic                   reg_write_c;
    logic                   alu_src_a_c;
    logic [1:0]             alu_src_b_c;
    logic [1:0]             alu_op_c;

    always_comb begin
        opcode_known = 1'b0;
        case (opcode)
            OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: opcode_known = 1'b1;
            default:                              opcode_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IF;
            illegal_op_q   <= 1'b0;
            cycle_count_q  <= '0;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            illegal_op_q   <= illegal_op_d;
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF: begin
                if (mem_ready) begin
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                case (opcode)
                    OP_ARITHMETIC, OP_ARITHMETIC_IMM,
                    OP_LOAD, OP_STORE, OP_BRANCH: state_d = ST_EX;
                    OP_JAL, OP_JALR:              state_d = ST_JMP;
                    OP_ECALL:                     state_d = halt_cond ? ST_HALT : ST_IF;
                    default:                      state_d = ST_HALT;
                endcase
            end
            ST_EX: begin
                case (opcode)
                    OP_ARITHMETIC, OP_ARITHMETIC_IMM: state_d = ST_WB;
                    OP_LOAD, OP_STORE:                state_d = ST_MEM;
                    OP_BRANCH:                        state_d = bcond ? ST_BRT : ST_IF;
                    default:                          state_d = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode == OP_STORE) ? ST_IF : ST_WB;
                end
            end
            ST_WB, ST_JMP, ST_BRT: state_d = ST_IF;
            ST_HALT:               state_d = ST_HALT;
            default:               state_d = ST_IF;
        endcase
    end

    // Control decode; pc_write always coincides with the retiring cycle of an instruction.
    always_comb begin
        pc_write_c   = 1'b0;
        pc_source_c  = 1'b0;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRC_B_REG;
        alu_op_c     = ALU_ADD;
        retire       = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_read_c = 1'b1;
                ir_write_c = mem_ready;
            end
            ST_ID: begin
                alu_src_b_c = SRC_B_FOUR;
                if (opcode == OP_ECALL && !halt_cond) begin
                    pc_write_c = 1'b1;
                    retire     = 1'b1;
                end
            end
            ST_EX: begin
                alu_src_a_c = 1'b1;
                case (opcode)
                    OP_ARITHMETIC: begin
                        alu_op_c = ALU_FUNCT;
                    end
                    OP_ARITHMETIC_IMM: begin
                        alu_src_b_c = SRC_B_IMM;
                        alu_op_c    = ALU_FUNCT;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b_c = SRC_B_IMM;
                    end
                    OP_BRANCH: begin
                        alu_op_c = ALU_BRANCH;
                        if (!bcond) begin
                            pc_write_c  = 1'b1;
                            pc_source_c = 1'b1;
                            retire      = 1'b1;
                        end
                    end
                    default: begin
                        alu_src_a_c = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                i_or_d_c = 1'b1;
                if (opcode == OP_STORE) begin
                    mem_write_c = 1'b1;
                    if (mem_ready) begin
                        pc_write_c  = 1'b1;
                        pc_source_c = 1'b1;
                        retire      = 1'b1;
                    end
                end else begin
                    mem_read_c = 1'b1;
                end
            end
            ST_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (opcode == OP_LOAD);
                pc_write_c   = 1'b1;
                pc_source_c  = 1'b1;
                retire       = 1'b1;
            end
            ST_JMP: begin
                reg_write_c = 1'b1;
                alu_src_a_c = (opcode == OP_JALR);
                alu_src_b_c = SRC_B_IMM;
                pc_write_c  = 1'b1;
                retire      = 1'b1;
            end
            ST_BRT: begin
                alu_src_b_c = SRC_B_IMM;
                pc_write_c  = 1'b1;
                retire      = 1'b1;
            end
            default: begin
                retire = 1'b0;
            end
        endcase
    end

    always_comb begin
        illegal_op_d   = illegal_op_q | ((state_q == ST_ID) && !opcode_known);
        cycle_count_d  = (state_q == ST_HALT) ? cycle_count_q : cycle_count_q + CNT_WIDTH'(1);
        retire_count_d = retire_count_q + CNT_WIDTH'(retire);
    end

    // Reset holds state at IF, so the strobes are gated to keep memory quiet while reset is low.
    always_comb begin
        pc_write   = reset & pc_write_c;
        pc_source  = reset & pc_source_c;
        i_or_d     = reset & i_or_d_c;
        mem_read   = reset & mem_read_c;
        mem_write  = reset & mem_write_c;
        ir_write   = reset & ir_write_c;
        mem_to_reg = reset & mem_to_reg_c;
        reg_write  = reset & reg_write_c;
        alu_src_a  = reset & alu_src_a_c;
        alu_src_b  = reset ? alu_src_b_c : 2'b00;
        alu_op     = reset ? alu_op_c : 2'b00;
    end

    assign state        = state_q;
    assign is_halted    = (state_q == ST_HALT);
    assign illegal_op   = illegal_op_q;
    assign cycle_count  = cycle_count_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each row of stimulus pushes the
// hand-derived control vector and counter values expected in that cycle.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // {pcw,pcs,iord,mr,mw,irw,m2r,rw,a}, alu_src_b, alu_op, state, {is_halted, illegal_op}
    localparam logic [17:0] E_RST   = 18'b0;
    localparam logic [17:0] E_IF    = {9'b000101000, 2'b00, 2'b00, 3'd0, 2'b00};
    localparam logic [17:0] E_IFW   = {9'b000100000, 2'b00, 2'b00, 3'd0, 2'b00};
    localparam logic [17:0] E_ID    = {9'b000000000, 2'b01, 2'b00, 3'd1, 2'b00};
    localparam logic [17:0] E_IDGO  = {9'b100000000, 2'b01, 2'b00, 3'd1, 2'b00};
    localparam logic [17:0] E_EXR   = {9'b000000001, 2'b00, 2'b10, 3'd2, 2'b00};
    localparam logic [17:0] E_EXI   = {9'b000000001, 2'b10, 2'b10, 3'd2, 2'b00};
    localparam logic [17:0] E_EXLS  = {9'b000000001, 2'b10, 2'b00, 3'd2, 2'b00};
    localparam logic [17:0] E_EXBN  = {9'b110000001, 2'b00, 2'b01, 3'd2, 2'b00};
    localparam logic [17:0] E_EXBT  = {9'b000000001, 2'b00, 2'b01, 3'd2, 2'b00};
    localparam logic [17:0] E_MEMLD = {9'b001100000, 2'b00, 2'b00, 3'd3, 2'b00};
    localparam logic [17:0] E_MEMSW = {9'b001010000, 2'b00, 2'b00, 3'd3, 2'b00};
    localparam logic [17:0] E_MEMSD = {9'b111010000, 2'b00, 2'b00, 3'd3, 2'b00};
    localparam logic [17:0] E_WBR   = {9'b110000010, 2'b00, 2'b00, 3'd4, 2'b00};
    localparam logic [17:0] E_WBLD  = {9'b110000110, 2'b00, 2'b00, 3'd4, 2'b00};
    localparam logic [17:0] E_JAL   = {9'b100000010, 2'b10, 2'b00, 3'd5, 2'b00};
    localparam logic [17:0] E_JALR  = {9'b100000011, 2'b10, 2'b00, 3'd5, 2'b00};
    localparam logic [17:0] E_BRT   = {9'b100000000, 2'b10, 2'b00, 3'd6, 2'b00};
    localparam logic [17:0] E_HALT  = {9'b000000000, 2'b00, 2'b00, 3'd7, 2'b10};
    localparam logic [17:0] E_HALTI = {9'b000000000, 2'b00, 2'b00, 3'd7, 2'b11};

    typedef struct packed {
        logic [6:0]  opc;
        logic        bc;
        logic        hc;
        logic        rdy;
        logic [17:0] ctl;
    } row_t;

    typedef struct packed {
        logic [17:0] ctl;
        logic [31:0] cyc;
        logic [31:0] ret;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        bcond;
    logic        halt_cond;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        is_halted;
    logic        illegal_op;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;

    int          checks;
    int          failures;
    sb_t         sb[$];
    logic [31:0] m_cycle;
    logic [31:0] m_retire;

    multicycle_control_unit #(.CNT_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .bcond        (bcond),
        .halt_cond    (halt_cond),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_source    (pc_source),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .state        (state),
        .is_halted    (is_halted),
        .illegal_op   (illegal_op),
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] obs();
        return {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, state, is_halted, illegal_op};
    endfunction

    function automatic row_t mkrow(input logic [6:0] opc, input logic bc, input logic hc,
                                   input logic rdy, input logic [17:0] ctl);
        row_t r;
        r.opc = opc; r.bc = bc; r.hc = hc; r.rdy = rdy; r.ctl = ctl;
        return r;
    endfunction

    // Drives one cycle of inputs, records what that cycle must show, then moves to the sample edge.
    task automatic drive(input row_t r);
        sb_t e;
        opcode    = r.opc;
        bcond     = r.bc;
        halt_cond = r.hc;
        mem_ready = r.rdy;
        e.ctl = r.ctl;
        e.cyc = m_cycle;
        e.ret = m_retire;
        sb.push_back(e);
        if (r.ctl[4:2] != 3'd7) m_cycle = m_cycle + 32'd1;
        if (r.ctl[17]) m_retire = m_retire + 32'd1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        sb.delete();
        m_cycle  = '0;
        m_retire = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        opcode    = OP_ADD;
        bcond     = 1'b1;
        halt_cond = 1'b1;
        mem_ready = 1'b1;
        m_cycle   = '0;
        m_retire  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== E_RST) begin
                failures++;
                $display("[TB] FAIL reset_ctl cycle %0d: got %b want %b", i, obs(), E_RST);
            end
            checks++;
            if (cycle_count !== 32'd0 || retire_count !== 32'd0 || illegal_op !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_cnt cycle %0d: got cyc=%0d ret=%0d ill=%b want 0/0/0",
                         i, cycle_count, retire_count, illegal_op);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_add();
        row_t rows[$];
        sb_t  e;
        rows.push_back(mkrow(OP_ADD, 1'b1, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_ADD, 1'b1, 1'b0, 1'b1, E_ID));
        rows.push_back(mkrow(OP_ADD, 1'b1, 1'b0, 1'b1, E_EXR));
        rows.push_back(mkrow(OP_ADD, 1'b1, 1'b0, 1'b1, E_WBR));
        rows.push_back(mkrow(OP_ADDI, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_ADDI, 1'b0, 1'b0, 1'b1, E_ID));
        rows.push_back(mkrow(OP_ADDI, 1'b0, 1'b0, 1'b1, E_EXI));
        rows.push_back(mkrow(OP_ADDI, 1'b0, 1'b0, 1'b1, E_WBR));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL add_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL add_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_stall();
        row_t rows[$];
        sb_t  e;
        rows.push_back(mkrow(OP_LW, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_LW, 1'b0, 1'b0, 1'b0, E_ID));
        rows.push_back(mkrow(OP_LW, 1'b0, 1'b0, 1'b0, E_EXLS));
        rows.push_back(mkrow(OP_LW, 1'b0, 1'b0, 1'b0, E_MEMLD));
        rows.push_back(mkrow(OP_LW, 1'b0, 1'b0, 1'b0, E_MEMLD));
        rows.push_back(mkrow(OP_LW, 1'b0, 1'b0, 1'b1, E_MEMLD));
        rows.push_back(mkrow(OP_LW, 1'b0, 1'b0, 1'b1, E_WBLD));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL load_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL load_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        sb_t  e;
        rows.push_back(mkrow(OP_BR, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_BR, 1'b1, 1'b0, 1'b1, E_ID));
        rows.push_back(mkrow(OP_BR, 1'b0, 1'b0, 1'b1, E_EXBN));
        rows.push_back(mkrow(OP_BR, 1'b1, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_BR, 1'b0, 1'b0, 1'b1, E_ID));
        rows.push_back(mkrow(OP_BR, 1'b1, 1'b0, 1'b1, E_EXBT));
        rows.push_back(mkrow(OP_BR, 1'b0, 1'b0, 1'b1, E_BRT));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL branch_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL branch_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jumps();
        row_t rows[$];
        sb_t  e;
        rows.push_back(mkrow(OP_JAL, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_JAL, 1'b0, 1'b0, 1'b1, E_ID));
        rows.push_back(mkrow(OP_JAL, 1'b0, 1'b0, 1'b1, E_JAL));
        rows.push_back(mkrow(OP_JALR, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_JALR, 1'b0, 1'b0, 1'b1, E_ID));
        rows.push_back(mkrow(OP_JALR, 1'b0, 1'b0, 1'b1, E_JALR));
        rows.push_back(mkrow(OP_ECALL, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_ECALL, 1'b0, 1'b0, 1'b1, E_IDGO));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL jump_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL jump_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store_stall();
        row_t rows[$];
        sb_t  e;
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_IFW));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_IFW));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_ID));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_EXLS));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_MEMSW));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b1, E_MEMSD));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL store_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL store_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_store_reset();
        row_t rows[$];
        row_t after[$];
        sb_t  e;
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_ID));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_EXLS));
        rows.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b0, E_MEMSW));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL st_rst_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            if (i != rows.size() - 1) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || state !== 3'd0 || obs() !== E_RST) begin
            failures++;
            $display("[TB] FAIL st_rst_async: got mw=%b state=%0d ctl=%b want mw=0 state=0 ctl=%b",
                     mem_write, state, obs(), E_RST);
        end
        checks++;
        if (cycle_count !== 32'd0 || retire_count !== 32'd0) begin
            failures++;
            $display("[TB] FAIL st_rst_cnt: got cyc=%0d ret=%0d want 0/0", cycle_count, retire_count);
        end
        sb.delete();
        m_cycle  = '0;
        m_retire = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        after.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b1, E_IF));
        after.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b1, E_ID));
        after.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b1, E_EXLS));
        after.push_back(mkrow(OP_SW, 1'b0, 1'b0, 1'b1, E_MEMSD));
        foreach (after[i]) begin
            drive(after[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL st_rel_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL st_rel_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_halt_ecall();
        row_t rows[$];
        sb_t  e;
        rows.push_back(mkrow(OP_ECALL, 1'b0, 1'b1, 1'b1, E_IF));
        rows.push_back(mkrow(OP_ECALL, 1'b0, 1'b1, 1'b1, E_ID));
        for (int k = 0; k < 10; k++) begin
            rows.push_back(mkrow(OP_ADD, k[0], k[1], ~k[0], E_HALT));
        end
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL halt_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL halt_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        row_t rows[$];
        sb_t  e;
        rows.push_back(mkrow(OP_BAD, 1'b0, 1'b0, 1'b1, E_IF));
        rows.push_back(mkrow(OP_BAD, 1'b0, 1'b0, 1'b1, E_ID));
        rows.push_back(mkrow(OP_BAD, 1'b0, 1'b0, 1'b1, E_HALTI));
        rows.push_back(mkrow(OP_ADD, 1'b0, 1'b0, 1'b1, E_HALTI));
        rows.push_back(mkrow(OP_ECALL, 1'b0, 1'b0, 1'b1, E_HALTI));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            checks++;
            if (obs() !== e.ctl) begin
                failures++;
                $display("[TB] FAIL illegal_ctl row %0d: got %b want %b", i, obs(), e.ctl);
            end
            checks++;
            if (cycle_count !== e.cyc || retire_count !== e.ret) begin
                failures++;
                $display("[TB] FAIL illegal_cnt row %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                         i, cycle_count, retire_count, e.cyc, e.ret);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (illegal_op !== 1'b0 || is_halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_clear: got ill=%b halted=%b want 0/0", illegal_op, is_halted);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_load_stall();
        test_branch();
        test_jumps();
        test_store_stall();
        test_store_reset();
        test_halt_ecall();
        apply_reset();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the shared multi-cycle RV32I datapath: PC, IR, register file, single ALU, immediate generator and unified instruction/data memory.
- Each cycle it drives the mux selects, write enables and memory strobes, from the IR opcode and the ALU branch condition.
- It also keeps cycle and retired-instruction counters, and raises halt on ECALL with the halt condition, or on an illegal opcode.

Parameters:
- CNT_WIDTH, 32, width of cycle_count and retire_count (wrap modulo 2^CNT_WIDTH).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  IR[6:0]; uses the opcode macros in opcodes.v.
- bcond  input  1  ALU compare result; sampled only in EX for BRANCH.
- halt_cond  input  1  x17==10; sampled only in ID for ECALL.
- mem_ready  input  1  memory completes the access this cycle.
- pc_write  output  1  PC load enable.
- pc_source  output  1  0 = live ALU result, 1 = ALUOut register.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs1 register A.
- alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = immediate.
- alu_op  output  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- state  output  3  current state, for debug.
- is_halted  output  1  high in HALT.
- illegal_op  output  1  sticky; set on an unknown opcode in ID.
- cycle_count  output  CNT_WIDTH  cycles since reset deassertion.
- retire_count  output  CNT_WIDTH  instructions retired.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, JMP=5, BRT=6, HALT=7.
- Reset (reset=0), asynchronous:
  - state <= IF; counters <= 0; illegal_op <= 0.
  - While reset is low, every strobe and enable output is forced to 0, and all selects are 0.
  - Reset mid-access aborts the access; fetch restarts on the first edge after release.
- Outputs are Moore, except the mem_ready-qualified enables and the EX branch PC update. Any output not listed in a state is 0.
- IF:
  - i_or_d=0, mem_read=1.
  - If mem_ready: ir_write=1, next state ID.
  - Otherwise stay in IF with no IR write.
- ID:
  - alu_src_a=0, alu_src_b=01, alu_op=00, so ALUOut <= PC+4.
  - ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH -> EX.
  - JAL, JALR -> JMP.
  - ECALL with halt_cond=1 -> HALT.
  - ECALL with halt_cond=0: pc_write=1, pc_source=0, retire, next IF.
  - Any other opcode: illegal_op <= 1, next HALT.
- EX:
  - ARITHMETIC: a=1, b=00, op=10 -> WB.
  - ARITHMETIC_IMM: a=1, b=10, op=10 -> WB.
  - LOAD/STORE: a=1, b=10, op=00 -> MEM.
  - BRANCH: a=1, b=00, op=01.
    - bcond=1 -> BRT.
    - bcond=0: pc_write=1, pc_source=1, retire, next IF.
- MEM:
  - LOAD: i_or_d=1, mem_read=1. If mem_ready -> WB, else stay.
  - STORE: i_or_d=1, mem_write=1. If mem_ready: pc_write=1, pc_source=1, retire, next IF. Else stay with mem_write held high.
- WB:
  - reg_write=1, mem_to_reg=(opcode==LOAD).
  - pc_write=1, pc_source=1, retire, next IF.
- JMP:
  - reg_write=1, mem_to_reg=0, so rd <= PC+4.
  - alu_src_a = 0 for JAL, 1 for JALR; alu_src_b=10; op=00.
  - pc_write=1, pc_source=0, retire, next IF.
- BRT:
  - a=0, b=10, op=00.
  - pc_write=1, pc_source=0, retire, next IF.
- HALT:
  - All strobes 0, is_halted=1.
  - Absorbing state; only reset leaves it.
- Counters:
  - cycle_count increments every cycle after reset release, including stall cycles.
  - cycle_count freezes in HALT.
  - "retire" means retire_count +1 on that edge. Both counters wrap silently.
- Latencies with mem_ready tied high:
  - R/I-type: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - Branch not taken: 3 cycles.
  - Branch taken: 4 cycles.
  - JAL/JALR: 3 cycles.
  - ECALL non-halt: 2 cycles.
- Invariants:
  - mem_read and mem_write are never both 1.
  - At most one pc_write per instruction.

Test Plan:
- ADD (0110011), mem_ready=1: states IF,ID,EX,WB; reg_write=1 only in WB; retire_count 0->1 after 4 cycles.
- LOAD with mem_ready low 2 cycles in MEM: MEM held 3 cycles with mem_read=1, i_or_d=1; WB has mem_to_reg=1; total 7 cycles.
- BRANCH: bcond=0 -> IF after 3 cycles, pc_source=1. bcond=1 -> BRT with alu_src_a=0, alu_src_b=10, pc_source=0; 4 cycles.
- JALR: ID->JMP; JMP has reg_write=1, alu_src_a=1, pc_write=1, pc_source=0; retire_count +1.
- ECALL: halt_cond=1 -> HALT; is_halted=1; cycle_count frozen for 10 further cycles. Opcode 7'b1111111 -> HALT with illegal_op=1.
- reset low during MEM of a STORE: mem_write drops to 0 immediately (asynchronous); counters=0; first cycle after release is IF with mem_read=1.
